// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory: FSM states, fault codes, fetch pipeline metadata.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_RUN     = 2'd2
  } imem_state_t;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_MISALIGN = 2'd1,
    FLT_RANGE    = 2'd2,
    FLT_UNLOADED = 2'd3
  } fault_t;

  // RISC-V canonical NOP (addi x0, x0, 0)
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic   vld;
    fault_t fault;
  } fetch_meta_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port; read data one cycle after re.
// No backpressure; contents are never reset.
module sdp_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem.sv
// Loadable instruction memory: streamed program load, then fetches with fault checking; RD_LAT (1 or 2) cycle fetch latency.
// Loads accepted only before RUN, fetches only in RUN at one per cycle; clear flushes program and in-flight fetches.
module instr_mem
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned RD_LAT   = 1,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [31:0]              load_data,
  input  logic                     load_last,
  input  logic                     fetch_req,
  input  logic [31:0]              fetch_addr,
  output logic                     fetch_ready,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [1:0]               instr_fault,
  output logic [$clog2(DEPTH):0]   loaded_cnt
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  if (DEPTH < 16 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_mem: DEPTH must be a power of 2 in 16..4096");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("instr_mem: RD_LAT must be 1 or 2");
  end

  imem_state_t state_q, state_d;
  fault_t      fetch_fault;
  logic        load_fire, fetch_fire;
  logic [AW-1:0] word_idx;
  logic [31:0] ram_q;
  logic [31:0] instr_hold;
  fetch_meta_t s1_meta, out_meta;
  logic [31:0] out_dat;

  assign load_ready  = (state_q != ST_RUN);
  assign fetch_ready = (state_q == ST_RUN);
  assign load_fire   = load_valid && load_ready && !clear;
  assign fetch_fire  = fetch_req && fetch_ready && !clear;
  assign word_idx    = fetch_addr[AW+1:2];

  // Priority order: misaligned, then beyond the array, then beyond the loaded program.
  always_comb begin
    fetch_fault = FLT_NONE;
    if (fetch_addr[1:0] != 2'b00)
      fetch_fault = FLT_MISALIGN;
    else if (|fetch_addr[31:AW+2])
      fetch_fault = FLT_RANGE;
    else if ({1'b0, word_idx} >= loaded_cnt)
      fetch_fault = FLT_UNLOADED;
  end

  always_comb begin
    state_d = state_q;
    if (clear)
      state_d = ST_EMPTY;
    else if (load_fire)
      state_d = (load_last || loaded_cnt == LAST_IDX) ? ST_RUN : ST_LOADING;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      loaded_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (clear)
        loaded_cnt <= '0;
      else if (load_fire)
        loaded_cnt <= loaded_cnt + CNT_W'(1);
    end
  end

  sdp_ram #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (load_fire),
    .waddr (loaded_cnt[AW-1:0]),
    .wdata (load_data),
    .re    (fetch_fire && fetch_fault == FLT_NONE),
    .raddr (word_idx),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_meta <= '{vld: 1'b0, fault: FLT_NONE};
    end else if (clear) begin
      s1_meta.vld <= 1'b0;
    end else begin
      s1_meta.vld   <= fetch_fire;
      s1_meta.fault <= fetch_fault;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    fetch_meta_t s2_meta;
    logic [31:0] s2_dat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_meta <= '{vld: 1'b0, fault: FLT_NONE};
      end else if (clear) begin
        s2_meta.vld <= 1'b0;
      end else begin
        s2_meta <= s1_meta;
      end
    end

    always_ff @(posedge clk) begin
      if (s1_meta.vld) s2_dat <= ram_q;
    end

    assign out_meta = s2_meta;
    assign out_dat  = s2_dat;
  end else begin : g_lat1
    assign out_meta = s1_meta;
    assign out_dat  = ram_q;
  end

  // instr_hold keeps the last presented word so instr is stable between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instr_hold <= '0;
    else if (out_meta.vld)
      instr_hold <= instr;
  end

  assign instr_valid = out_meta.vld;
  assign instr_fault = out_meta.vld ? out_meta.fault : FLT_NONE;
  assign instr       = !out_meta.vld ? instr_hold :
                       (out_meta.fault != FLT_NONE) ? NOP_WORD : out_dat;

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench: instance 0 is DEPTH=1024/RD_LAT=1, instance 1 is DEPTH=16/RD_LAT=2.
module tb_instr_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear [2];
  logic        load_valid [2];
  logic        load_last [2];
  logic        fetch_req [2];
  logic [31:0] load_data [2];
  logic [31:0] fetch_addr [2];
  logic        load_ready [2];
  logic        fetch_ready [2];
  logic        instr_valid [2];
  logic [31:0] instr [2];
  logic [1:0]  instr_fault [2];
  logic [10:0] cnt_a;
  logic [4:0]  cnt_b;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  instr_mem #(.DEPTH(1024), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]),
    .load_valid(load_valid[0]), .load_ready(load_ready[0]), .load_data(load_data[0]),
    .load_last(load_last[0]), .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]),
    .fetch_ready(fetch_ready[0]), .instr_valid(instr_valid[0]), .instr(instr[0]),
    .instr_fault(instr_fault[0]), .loaded_cnt(cnt_a)
  );

  instr_mem #(.DEPTH(16), .RD_LAT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]),
    .load_valid(load_valid[1]), .load_ready(load_ready[1]), .load_data(load_data[1]),
    .load_last(load_last[1]), .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]),
    .fetch_ready(fetch_ready[1]), .instr_valid(instr_valid[1]), .instr(instr[1]),
    .instr_fault(instr_fault[1]), .loaded_cnt(cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int k, input logic [31:0] d, input logic last);
    load_valid[k] = 1'b1;
    load_data[k]  = d;
    load_last[k]  = last;
    tick();
    load_valid[k] = 1'b0;
    load_last[k]  = 1'b0;
  endtask

  task automatic fetch(input int k, input logic [31:0] addr);
    fetch_req[k]  = 1'b1;
    fetch_addr[k] = addr;
    tick();
    fetch_req[k]  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int k, input logic vld,
                         input logic [31:0] ins, input logic [1:0] flt);
    chk({tag, "_vld"}, 32'(instr_valid[k]), 32'(vld));
    chk({tag, "_instr"}, instr[k], ins);
    chk({tag, "_fault"}, 32'(instr_fault[k]), 32'(flt));
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h1111_0001;
    prog[1] = 32'h2222_0002;
    prog[2] = 32'h3333_0003;
    prog[3] = 32'h4444_0004;
    for (int k = 0; k < 2; k++) begin
      clear[k] = 1'b0; load_valid[k] = 1'b0; load_last[k] = 1'b0;
      fetch_req[k] = 1'b0; load_data[k] = '0; fetch_addr[k] = '0;
    end

    // Reset state while rst_n is held low
    #3;
    chk("rst_load_ready", 32'(load_ready[0]), 32'd1);
    chk("rst_fetch_ready", 32'(fetch_ready[0]), 32'd0);
    chk_out("rst_out", 0, 1'b0, 32'h0, 2'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Load four words, last on the fourth
    for (int i = 0; i < 4; i++) load_word(0, prog[i], i == 3);
    chk("load4_cnt", 32'(cnt_a), 32'd4);
    chk("load4_fetch_ready", 32'(fetch_ready[0]), 32'd1);
    chk("load4_load_ready", 32'(load_ready[0]), 32'd0);

    // Back-to-back fetches, each result one cycle later
    for (int i = 0; i < 4; i++) begin
      fetch(0, 32'(4 * i));
      chk_out($sformatf("b2b%0d", i), 0, 1'b1, prog[i], 2'd0);
    end
    tick();
    chk_out("idle_hold", 0, 1'b0, prog[3], 2'd0);

    // Faulted fetches: misaligned, unloaded, out of range
    fetch(0, 32'h0000_0002);
    chk_out("flt_misalign", 0, 1'b1, 32'h0000_0013, 2'd1);
    fetch(0, 32'h0000_0010);
    chk_out("flt_unloaded", 0, 1'b1, 32'h0000_0013, 2'd3);
    fetch(0, 32'h0000_1000);
    chk_out("flt_range", 0, 1'b1, 32'h0000_0013, 2'd2);

    // Plain clear from RUN
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    chk("clr_cnt", 32'(cnt_a), 32'd0);
    chk("clr_load_ready", 32'(load_ready[0]), 32'd1);
    chk("clr_fetch_ready", 32'(fetch_ready[0]), 32'd0);

    // load_last handshake coincident with clear: clear wins
    clear[0] = 1'b1;
    load_word(0, 32'hDEAD_BEEF, 1'b1);
    clear[0] = 1'b0;
    chk("clrlast_cnt", 32'(cnt_a), 32'd0);
    chk("clrlast_fetch_ready", 32'(fetch_ready[0]), 32'd0);
    chk("clrlast_load_ready", 32'(load_ready[0]), 32'd1);

    // DEPTH=16: fill the array without load_last
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("fill15_load_ready", 32'(load_ready[1]), 32'd1);
      load_word(1, 32'hB000_0000 + 32'(i), 1'b0);
    end
    chk("full_cnt", 32'(cnt_b), 32'd16);
    chk("full_load_ready", 32'(load_ready[1]), 32'd0);
    chk("full_fetch_ready", 32'(fetch_ready[1]), 32'd1);
    load_word(1, 32'hFFFF_FFFF, 1'b0);
    chk("extra_cnt", 32'(cnt_b), 32'd16);

    // RD_LAT=2 latency on the last word
    fetch(1, 32'h0000_003C);
    chk("lat2_early_vld", 32'(instr_valid[1]), 32'd0);
    tick();
    chk_out("lat2", 1, 1'b1, 32'hB000_000F, 2'd0);

    // Fetch in flight, second fetch coincident with clear: both dropped
    fetch(1, 32'h0000_0000);
    chk("inflight_vld", 32'(instr_valid[1]), 32'd0);
    clear[1] = 1'b1;
    fetch(1, 32'h0000_0004);
    clear[1] = 1'b0;
    for (int i = 0; i < 3; i++) chk($sformatf("drop_vld%0d", i), 32'(instr_valid[1]), 32'd0) ;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("drop_late_vld%0d", i), 32'(instr_valid[1]), 32'd0);
    end
    chk("drop_cnt", 32'(cnt_b), 32'd0);
    chk("drop_fetch_ready", 32'(fetch_ready[1]), 32'd0);
    chk("drop_load_ready", 32'(load_ready[1]), 32'd1);

    // Give instance 0 a nonzero held output, then reset asynchronously mid-load
    load_word(0, prog[0], 1'b1);
    fetch(0, 32'h0000_0002);
    chk_out("pre_rst", 0, 1'b1, 32'h0000_0013, 2'd1);
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    for (int i = 0; i < 3; i++) load_word(0, prog[i], 1'b0);
    chk("midload_cnt", 32'(cnt_a), 32'd3);
    #2 rst_n = 1'b0;
    #2;
    chk("arst_cnt", 32'(cnt_a), 32'd0);
    chk("arst_load_ready", 32'(load_ready[0]), 32'd1);
    chk("arst_fetch_ready", 32'(fetch_ready[0]), 32'd0);
    chk_out("arst_out", 0, 1'b0, 32'h0, 2'd0);
    #2 rst_n = 1'b1;
    tick();
    fetch(0, 32'h0000_0000);
    chk("postrst_fetch_ready", 32'(fetch_ready[0]), 32'd0);
    chk("postrst_vld0", 32'(instr_valid[0]), 32'd0);
    tick();
    chk("postrst_vld1", 32'(instr_valid[0]), 32'd0);
    load_word(0, 32'hCAFE_F00D, 1'b1);
    chk("reload_cnt", 32'(cnt_a), 32'd1);
    fetch(0, 32'h0000_0000);
    chk_out("reload_fetch", 0, 1'b1, 32'hCAFE_F00D, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit instruction words; the implementation SHALL accept only powers of 2 from 16 to 4096.
REQ-002 Parameter RD_LAT, default 1, fetch-to-instr latency in cycles; the implementation SHALL accept only 1 or 2.
REQ-003 Parameter NOP_WORD, default 32'h00000013, the word returned on any faulted fetch.
REQ-004 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port clear, input, 1, synchronous program flush.
REQ-007 Port load_valid, input, 1, a load word is offered.
REQ-008 Port load_ready, output, 1, the block accepts a load word.
REQ-009 Port load_data, input, 32, the program word to store.
REQ-010 Port load_last, input, 1, marks the final program word.
REQ-011 Port fetch_req, input, 1, a fetch request is presented.
REQ-012 Port fetch_addr, input, 32, byte PC of the fetch.
REQ-013 Port fetch_ready, output, 1, the block accepts a fetch.
REQ-014 Port instr_valid, output, 1, instr and instr_fault are valid this cycle.
REQ-015 Port instr, output, 32, the fetched instruction.
REQ-016 Port instr_fault, output, 2, fault code: 0 none, 1 misaligned, 2 out of range, 3 unloaded.
REQ-017 Port loaded_cnt, output, $clog2(DEPTH)+1, number of words loaded.

Function
REQ-018 The block SHALL implement a three-state FSM: EMPTY, LOADING and RUN.
REQ-019 A load handshake SHALL occur when load_valid and load_ready are both high.
REQ-020 load_ready SHALL be high only in EMPTY and LOADING.
REQ-021 Each load handshake SHALL write load_data to word index loaded_cnt and SHALL increment loaded_cnt by 1.
REQ-022 The first load handshake SHALL move the FSM from EMPTY to LOADING.
REQ-023 A handshake with load_last=1 SHALL move the FSM to RUN, from either EMPTY or LOADING.
REQ-024 A handshake that writes index DEPTH-1 SHALL move the FSM to RUN even when load_last=0; load_ready SHALL then be 0.
REQ-025 fetch_ready SHALL equal (state==RUN); fetch_req SHALL be ignored in any other state.
REQ-026 An accepted fetch SHALL produce instr_valid=1 exactly RD_LAT cycles later, one result per accepted fetch, in order.
REQ-027 Fetches SHALL be accepted back-to-back at full throughput, one per cycle.
REQ-028 The word index SHALL be fetch_addr[31:2].
REQ-029 If fetch_addr[1:0]!=0, the fault code SHALL be 1.
REQ-030 Otherwise, if the word index is >= DEPTH, the fault code SHALL be 2.
REQ-031 Otherwise, if the word index is >= loaded_cnt, the fault code SHALL be 3.
REQ-032 Fault priority SHALL be 1, then 2, then 3.
REQ-033 Any faulted fetch SHALL return instr=NOP_WORD; a non-faulted fetch SHALL return the stored word.
REQ-034 When instr_valid=0, instr SHALL hold its last value and instr_fault SHALL be 0.
REQ-035 clear=1 SHALL, on the next edge, force state EMPTY and loaded_cnt=0, and SHALL drop all in-flight fetches.
REQ-036 clear SHALL have priority over a simultaneous load_last handshake or fetch.
REQ-037 Memory contents SHALL be undefined after clear; they are unreachable because loaded_cnt=0.
REQ-038 Reads and writes SHALL never occur in the same cycle, since fetch is allowed only in RUN.

Reset
REQ-039 rst_n low SHALL immediately force state EMPTY and loaded_cnt=0.
REQ-040 rst_n low SHALL immediately force instr_valid=0, instr=32'h0 and instr_fault=0, and SHALL clear all latency pipeline valid bits.
REQ-041 rst_n low SHALL immediately force load_ready=1 and fetch_ready=0.
REQ-042 Reset asserted mid-load or mid-fetch SHALL discard the partial program and all in-flight fetches; no instr_valid SHALL appear after reset release.
REQ-043 Memory array contents SHALL NOT be reset.

Structure
REQ-044 A shared package imem_pkg SHALL hold the FSM state enum, the fault-code typedef and constants, and the default NOP_WORD.
REQ-045 A single sub-module sdp_ram (parametrised width and depth, one write port, one registered read port) SHALL hold the array; instr_mem SHALL own the FSM, the counters, the fault logic and the optional second pipeline stage.

Verification
REQ-046 Reset, then load 4 words with load_last on the 4th, then fetch 0x0, 0x4, 0x8, 0xC back-to-back with RD_LAT=1 -> the four words return on consecutive cycles 1 cycle after each request, fault 0, loaded_cnt=4.
REQ-047 With 4 words loaded, fetch 0x2, then 0x10, then 0x1000 with DEPTH=1024 -> instr=0x00000013 each time, with faults 1, 3 and 2 respectively.
REQ-048 DEPTH=16, load 16 words with load_last=0 -> RUN after the 16th handshake, load_ready=0, and a 17th load_valid is not accepted.
REQ-049 RD_LAT=2, with 2 fetches in flight, assert clear -> no instr_valid afterwards, state EMPTY, loaded_cnt=0, fetch_ready=0.
REQ-050 Assert rst_n=0 asynchronously mid-load after 3 words -> outputs take their reset values before the next clock edge; after release, a fetch is not accepted until a new load completes.
REQ-051 load_last handshake and clear in the same cycle -> state EMPTY and loaded_cnt=0.
